// File: rtl/conv_apb_pkg.sv
// Shared definitions for the conv accelerator APB register map and the
// job sequencer state/step encodings.
package conv_apb_pkg;

    localparam logic [31:0] ADDR_COMMAND      = 32'h0000_0000;
    localparam logic [31:0] ADDR_INPUT_LEN    = 32'h0000_0004;
    localparam logic [31:0] ADDR_OUTPUT_LEN   = 32'h0000_0008;
    localparam logic [31:0] ADDR_WIDTH        = 32'h0000_000C;
    localparam logic [31:0] ADDR_FEATURE_DONE = 32'h0000_0010;
    localparam logic [31:0] ADDR_BIAS_DONE    = 32'h0000_0014;
    localparam logic [31:0] ADDR_WEIGHT_DONE  = 32'h0000_0018;
    localparam logic [31:0] ADDR_CONV_DONE    = 32'h0000_001C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_GAP    = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        STEP_INPUT_LEN  = 3'd0,
        STEP_OUTPUT_LEN = 3'd1,
        STEP_WIDTH      = 3'd2,
        STEP_COMMAND    = 3'd3,
        STEP_POLL       = 3'd4,
        STEP_CLEAR      = 3'd5
    } step_e;

    function automatic logic [31:0] poll_addr(input logic [1:0] sel);
        logic [31:0] a;
        case (sel)
            2'd0:    a = ADDR_FEATURE_DONE;
            2'd1:    a = ADDR_BIAS_DONE;
            2'd2:    a = ADDR_WEIGHT_DONE;
            default: a = ADDR_CONV_DONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: a request launches SETUP, the next cycle is
// ACCESS, and the bus returns to all-zero unless another request arrives.
module apb_master_xfer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_write,
    input  logic [31:0] i_wdata,
    output logic        o_xfer_done,
    output logic [31:0] o_rdata,
    output logic [31:0] o_paddr,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_pwdata,
    input  logic [31:0] i_prdata
);

    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    // Handshake: i_req may be raised only while the engine is idle or in the
    // ACCESS cycle (o_xfer_done=1); it is taken that same edge, which gives
    // back-to-back transfers with no idle cycle. o_rdata is valid with o_xfer_done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
        end else if (i_req) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= i_write;
            r_paddr   <= i_addr;
            r_pwdata  <= i_wdata;
        end else if (r_psel && !r_penable) begin
            r_penable <= 1'b1;
        end else begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
        end
    end

    assign o_xfer_done = r_psel & r_penable;
    assign o_rdata     = i_prdata;
    assign o_paddr     = r_paddr;
    assign o_psel      = r_psel;
    assign o_penable   = r_penable;
    assign o_pwrite    = r_pwrite;
    assign o_pwdata    = r_pwdata;

endmodule

// File: rtl/conv_apb_sequencer.sv
// Programs one conv job over APB: four config writes, poll a done flag with
// optional gap and limit, clear the command, then pulse done (and timeout).
module conv_apb_sequencer
    import conv_apb_pkg::*;
#(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic        PCLK,
    input  logic        PRESETB,
    input  logic        start,
    input  logic [2:0]  cfg_command,
    input  logic [8:0]  cfg_input_len,
    input  logic [8:0]  cfg_output_len,
    input  logic [8:0]  cfg_width,
    input  logic [1:0]  cfg_wait_sel,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] last_status,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    output logic [2:0]  dbg_state
);

    localparam logic [15:0] MAX_POLLS_L = 16'(MAX_POLLS);
    localparam logic [15:0] GAP_LOAD    = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    state_e      r_state;
    step_e       r_step;
    logic [2:0]  r_cmd;
    logic [8:0]  r_out_len;
    logic [8:0]  r_width;
    logic [1:0]  r_wait_sel;
    logic [15:0] r_poll_cnt;
    logic [15:0] r_gap_cnt;
    logic        r_to_flag;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_last_status;

    logic        w_req;
    step_e       w_next_step;
    logic [31:0] w_addr;
    logic        w_write;
    logic [31:0] w_wdata;
    logic        w_xfer_done;
    logic [31:0] w_rdata;
    logic [15:0] w_poll_cnt_inc;
    logic        w_flag_set;
    logic        w_limit_hit;

    apb_master_xfer u_xfer (
        .i_clk       (PCLK),
        .i_rst_n     (PRESETB),
        .i_req       (w_req),
        .i_addr      (w_addr),
        .i_write     (w_write),
        .i_wdata     (w_wdata),
        .o_xfer_done (w_xfer_done),
        .o_rdata     (w_rdata),
        .o_paddr     (PADDR),
        .o_psel      (PSEL),
        .o_penable   (PENABLE),
        .o_pwrite    (PWRITE),
        .o_pwdata    (PWDATA),
        .i_prdata    (PRDATA)
    );

    // Next-transfer decision; shared by the FSM and the transfer request.
    always_comb begin
        w_poll_cnt_inc = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
        w_flag_set     = w_rdata[0];
        w_limit_hit    = (MAX_POLLS_L != 16'd0) && (w_poll_cnt_inc == MAX_POLLS_L);
        w_req          = 1'b0;
        w_next_step    = r_step;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_req       = 1'b1;
                    w_next_step = STEP_INPUT_LEN;
                end
            end
            ST_ACCESS: begin
                if (w_xfer_done) begin
                    case (r_step)
                        STEP_INPUT_LEN, STEP_OUTPUT_LEN, STEP_WIDTH, STEP_COMMAND: begin
                            w_req       = 1'b1;
                            w_next_step = step_e'(r_step + 3'd1);
                        end
                        STEP_POLL: begin
                            if (w_flag_set || w_limit_hit) begin
                                w_req       = 1'b1;
                                w_next_step = STEP_CLEAR;
                            end else if (POLL_GAP == 0) begin
                                w_req = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 16'd0) begin
                    w_req       = 1'b1;
                    w_next_step = STEP_POLL;
                end
            end
            default: ;
        endcase
    end

    // Step 0 is only ever launched from IDLE, so its data comes straight
    // from the start-cycle input; every later step uses latched values.
    always_comb begin
        w_addr  = ADDR_COMMAND;
        w_write = 1'b1;
        w_wdata = 32'd0;
        case (w_next_step)
            STEP_INPUT_LEN:  begin w_addr = ADDR_INPUT_LEN;  w_wdata = {23'd0, cfg_input_len}; end
            STEP_OUTPUT_LEN: begin w_addr = ADDR_OUTPUT_LEN; w_wdata = {23'd0, r_out_len}; end
            STEP_WIDTH:      begin w_addr = ADDR_WIDTH;      w_wdata = {23'd0, r_width}; end
            STEP_COMMAND:    begin w_addr = ADDR_COMMAND;    w_wdata = {29'd0, r_cmd}; end
            STEP_POLL:       begin w_addr = poll_addr(r_wait_sel); w_write = 1'b0; end
            default:         begin w_addr = ADDR_COMMAND;    w_wdata = 32'd0; end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) begin
            r_state       <= ST_IDLE;
            r_step        <= STEP_INPUT_LEN;
            r_cmd         <= 3'd0;
            r_out_len     <= 9'd0;
            r_width       <= 9'd0;
            r_wait_sel    <= 2'd0;
            r_poll_cnt    <= 16'd0;
            r_gap_cnt     <= 16'd0;
            r_to_flag     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_last_status <= 32'd0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (w_req) begin
                r_state <= ST_SETUP;
                r_step  <= w_next_step;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cmd      <= cfg_command;
                        r_out_len  <= cfg_output_len;
                        r_width    <= cfg_width;
                        r_wait_sel <= cfg_wait_sel;
                        r_poll_cnt <= 16'd0;
                        r_to_flag  <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SETUP: r_state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (w_xfer_done && r_step == STEP_POLL) begin
                        r_last_status <= w_rdata;
                        r_poll_cnt    <= w_poll_cnt_inc;
                        if (!w_flag_set && w_limit_hit) r_to_flag <= 1'b1;
                        if (!w_req) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end
                    end else if (w_xfer_done && r_step == STEP_CLEAR) begin
                        r_state   <= ST_FIN;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= r_to_flag;
                    end
                end
                ST_GAP: begin
                    if (!w_req) r_gap_cnt <= r_gap_cnt - 16'd1;
                end
                ST_FIN: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign last_status = r_last_status;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_conv_apb_sequencer.sv
// Directed bench for conv_apb_sequencer: two instances (default parameters,
// and POLL_GAP=0/MAX_POLLS=2) driven against a shared APB slave model.
module tb_conv_apb_sequencer;
  import conv_apb_pkg::*;

  logic        PCLK;
  logic        PRESETB;
  logic        start_a, start_b;
  logic [2:0]  cfg_command;
  logic [8:0]  cfg_input_len, cfg_output_len, cfg_width;
  logic [1:0]  cfg_wait_sel;

  logic        busy_a, done_a, timeout_a, psel_a, penable_a, pwrite_a;
  logic [31:0] last_status_a, paddr_a, pwdata_a;
  logic [2:0]  dbg_state_a;
  logic        busy_b, done_b, timeout_b, psel_b, penable_b, pwrite_b;
  logic [31:0] last_status_b, paddr_b, pwdata_b;
  logic [2:0]  dbg_state_b;
  logic [31:0] slv_prdata;

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  conv_apb_sequencer #(.POLL_GAP(4), .MAX_POLLS(1024)) dut_a (
    .PCLK(PCLK), .PRESETB(PRESETB), .start(start_a),
    .cfg_command(cfg_command), .cfg_input_len(cfg_input_len),
    .cfg_output_len(cfg_output_len), .cfg_width(cfg_width), .cfg_wait_sel(cfg_wait_sel),
    .busy(busy_a), .done(done_a), .timeout(timeout_a), .last_status(last_status_a),
    .PADDR(paddr_a), .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a),
    .PWDATA(pwdata_a), .PRDATA(slv_prdata), .dbg_state(dbg_state_a)
  );

  conv_apb_sequencer #(.POLL_GAP(0), .MAX_POLLS(2)) dut_b (
    .PCLK(PCLK), .PRESETB(PRESETB), .start(start_b),
    .cfg_command(cfg_command), .cfg_input_len(cfg_input_len),
    .cfg_output_len(cfg_output_len), .cfg_width(cfg_width), .cfg_wait_sel(cfg_wait_sel),
    .busy(busy_b), .done(done_b), .timeout(timeout_b), .last_status(last_status_b),
    .PADDR(paddr_b), .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b),
    .PWDATA(pwdata_b), .PRDATA(slv_prdata), .dbg_state(dbg_state_b)
  );

  // ---------------- observed instance mux ----------------
  logic        sel;
  logic        mon_busy, mon_done, mon_timeout, mon_psel, mon_penable, mon_pwrite;
  logic [31:0] mon_last_status, mon_paddr, mon_pwdata;
  assign mon_busy        = sel ? busy_b        : busy_a;
  assign mon_done        = sel ? done_b        : done_a;
  assign mon_timeout     = sel ? timeout_b     : timeout_a;
  assign mon_psel        = sel ? psel_b        : psel_a;
  assign mon_penable     = sel ? penable_b     : penable_a;
  assign mon_pwrite      = sel ? pwrite_b      : pwrite_a;
  assign mon_last_status = sel ? last_status_b : last_status_a;
  assign mon_paddr       = sel ? paddr_b       : paddr_a;
  assign mon_pwdata      = sel ? pwdata_b      : pwdata_a;

  // ---------------- APB slave model ----------------
  // Done-flag registers read 1 from read number flag_on_read onward (0 = never).
  int   flag_on_read;
  int   rd_cnt;
  logic clr_rd;
  always @(posedge PCLK) begin
    if (clr_rd) rd_cnt <= 0;
    else if (mon_psel && mon_penable && !mon_pwrite) rd_cnt <= rd_cnt + 1;
  end
  always_comb begin
    slv_prdata = 32'd0;
    if (mon_paddr >= ADDR_FEATURE_DONE && mon_paddr <= ADDR_CONV_DONE)
      slv_prdata = (flag_on_read != 0 && rd_cnt + 1 >= flag_on_read) ? 32'd1 : 32'd0;
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  int          rd_cyc_q[$];
  int          n_assert, n_fail;
  int          done_cyc, n_done, busy_err, to_err, psel_cnt;
  logic        to_at_done;

  function automatic logic [64:0] rec(input logic w, input logic [31:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_records(input string tag);
    chk({tag, "_n_xfers"}, 65'(got_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), (i < got_q.size()) ? got_q[i] : '1, exp_q[i]);
  endtask

  task automatic push_cfg_writes(input logic [8:0] il, input logic [8:0] ol,
                                 input logic [8:0] w, input logic [2:0] c);
    exp_q.delete();
    exp_q.push_back(rec(1'b1, ADDR_INPUT_LEN,  {23'd0, il}));
    exp_q.push_back(rec(1'b1, ADDR_OUTPUT_LEN, {23'd0, ol}));
    exp_q.push_back(rec(1'b1, ADDR_WIDTH,      {23'd0, w}));
    exp_q.push_back(rec(1'b1, ADDR_COMMAND,    {29'd0, c}));
  endtask

  // ---------------- driver ----------------
  // Start is high in cycle 0; the loop samples cycle k at its falling edge,
  // then sets the inputs for that cycle's closing rising edge.
  task automatic run_job(input logic use_b, input int budget, input int xs1,
                         input int xs2, input logic chg_w);
    got_q.delete();
    rd_cyc_q.delete();
    done_cyc = -1; n_done = 0; busy_err = 0; to_err = 0; to_at_done = 1'b0;
    sel = use_b;
    @(negedge PCLK);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    clr_rd = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge PCLK);
      if (mon_psel && mon_penable) begin
        got_q.push_back(rec(mon_pwrite, mon_paddr, mon_pwrite ? mon_pwdata : slv_prdata));
        if (!mon_pwrite) rd_cyc_q.push_back(k);
      end
      if (mon_done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = k; to_at_done = mon_timeout; end
      end
      if (mon_timeout && !mon_done) to_err++;
      if (mon_busy !== (done_cyc < 0)) busy_err++;
      clr_rd = 1'b0;
      if (use_b) start_b = (k == xs1 || k == xs2);
      else       start_a = (k == xs1 || k == xs2);
      if (chg_w && k == 2) cfg_width = 9'd100;
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic set_cfg(input logic [8:0] il, input logic [8:0] ol, input logic [8:0] w,
                         input logic [2:0] c, input logic [1:0] ws);
    cfg_input_len = il; cfg_output_len = ol; cfg_width = w; cfg_command = c; cfg_wait_sel = ws;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert = 0; n_fail = 0;
    PRESETB = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    clr_rd = 1'b0; flag_on_read = 0;
    set_cfg(9'd0, 9'd0, 9'd0, 3'd0, 2'd0);
    #2 PRESETB = 1'b0;

    // Reset state and idle bus
    repeat (3) @(negedge PCLK);
    chk("rst_psel",    psel_a,    1'b0);
    chk("rst_penable", penable_a, 1'b0);
    chk("rst_pwrite",  pwrite_a,  1'b0);
    chk("rst_paddr",   paddr_a,   32'd0);
    chk("rst_pwdata",  pwdata_a,  32'd0);
    chk("rst_busy",    busy_a,    1'b0);
    chk("rst_done",    done_a,    1'b0);
    chk("rst_timeout", timeout_a, 1'b0);
    chk("rst_status",  last_status_a, 32'd0);
    chk("rst_b_psel",  psel_b,    1'b0);
    PRESETB = 1'b1;
    psel_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (psel_a || psel_b || busy_a || busy_b) psel_cnt++;
    end
    chk("idle_activity", psel_cnt, 0);

    // Success on the first poll of conv_done
    set_cfg(9'd32, 9'd64, 9'd28, 3'd3, 2'd3);
    flag_on_read = 1;
    run_job(1'b0, 30, -1, -1, 1'b0);
    push_cfg_writes(9'd32, 9'd64, 9'd28, 3'd3);
    exp_q.push_back(rec(1'b0, ADDR_CONV_DONE, 32'd1));
    exp_q.push_back(rec(1'b1, ADDR_COMMAND, 32'd0));
    check_records("basic");
    chk("basic_done_cyc",  done_cyc, 13);
    chk("basic_n_done",    n_done, 1);
    chk("basic_timeout",   to_at_done, 1'b0);
    chk("basic_busy",      busy_err, 0);
    chk("basic_status",    mon_last_status, 32'd1);
    chk("basic_read_cyc",  (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, 10);

    // Flag rises on the 3rd poll with a 4-cycle gap
    set_cfg(9'd511, 9'd1, 9'd256, 3'd5, 2'd3);
    flag_on_read = 3;
    run_job(1'b0, 40, -1, -1, 1'b0);
    push_cfg_writes(9'd511, 9'd1, 9'd256, 3'd5);
    exp_q.push_back(rec(1'b0, ADDR_CONV_DONE, 32'd0));
    exp_q.push_back(rec(1'b0, ADDR_CONV_DONE, 32'd0));
    exp_q.push_back(rec(1'b0, ADDR_CONV_DONE, 32'd1));
    exp_q.push_back(rec(1'b1, ADDR_COMMAND, 32'd0));
    check_records("gap");
    chk("gap_done_cyc", done_cyc, 25);
    chk("gap_timeout",  to_at_done, 1'b0);
    chk("gap_busy",     busy_err, 0);
    chk("gap_rd2_cyc",  (rd_cyc_q.size() > 1) ? rd_cyc_q[1] : -1, 16);
    chk("gap_rd3_cyc",  (rd_cyc_q.size() > 2) ? rd_cyc_q[2] : -1, 22);

    // Poll limit of 2 with no gap, weight_done never set
    set_cfg(9'd7, 9'd300, 9'd15, 3'd1, 2'd2);
    flag_on_read = 0;
    run_job(1'b1, 30, -1, -1, 1'b0);
    push_cfg_writes(9'd7, 9'd300, 9'd15, 3'd1);
    exp_q.push_back(rec(1'b0, ADDR_WEIGHT_DONE, 32'd0));
    exp_q.push_back(rec(1'b0, ADDR_WEIGHT_DONE, 32'd0));
    exp_q.push_back(rec(1'b1, ADDR_COMMAND, 32'd0));
    check_records("tmo");
    chk("tmo_done_cyc",  done_cyc, 15);
    chk("tmo_timeout",   to_at_done, 1'b1);
    chk("tmo_stray",     to_err, 0);
    chk("tmo_n_done",    n_done, 1);
    chk("tmo_status",    mon_last_status, 32'd0);

    // Start pulses while busy and in FIN, width changed after start
    set_cfg(9'd32, 9'd64, 9'd28, 3'd3, 2'd3);
    flag_on_read = 1;
    run_job(1'b0, 30, 3, 13, 1'b1);
    push_cfg_writes(9'd32, 9'd64, 9'd28, 3'd3);
    exp_q.push_back(rec(1'b0, ADDR_CONV_DONE, 32'd1));
    exp_q.push_back(rec(1'b1, ADDR_COMMAND, 32'd0));
    check_records("restart");
    chk("restart_done_cyc", done_cyc, 13);
    chk("restart_n_done",   n_done, 1);
    chk("restart_busy",     busy_err, 0);

    // Reset during the ACCESS of the 2nd write, then a clean job
    set_cfg(9'd32, 9'd64, 9'd28, 3'd3, 2'd3);
    sel = 1'b0;
    @(negedge PCLK); start_a = 1'b1;
    @(negedge PCLK); start_a = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("mid_access_psel",    psel_a & penable_a, 1'b1);
    chk("mid_access_paddr",   paddr_a, ADDR_OUTPUT_LEN);
    PRESETB = 1'b0;
    #1;
    chk("mid_rst_psel",    psel_a, 1'b0);
    chk("mid_rst_penable", penable_a, 1'b0);
    chk("mid_rst_busy",    busy_a, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESETB = 1'b1;
    psel_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (psel_a || busy_a) psel_cnt++;
    end
    chk("post_rst_idle", psel_cnt, 0);
    run_job(1'b0, 30, -1, -1, 1'b0);
    push_cfg_writes(9'd32, 9'd64, 9'd28, 3'd3);
    exp_q.push_back(rec(1'b0, ADDR_CONV_DONE, 32'd1));
    exp_q.push_back(rec(1'b1, ADDR_COMMAND, 32'd0));
    check_records("rerun");
    chk("rerun_done_cyc", done_cyc, 13);
    chk("rerun_busy",     busy_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_apb_sequencer.md
# conv_apb_sequencer

APB initiator that programs and runs one convolution job on the conv accelerator's APB register block. On a start pulse it writes the input length, output length, width and command registers, then polls a selected done flag until it is set or a poll limit expires. Finally it writes the command back to 0 and reports completion. It sits between the host-side control FSM and the accelerator's APB slave port. It replaces hand-driven APB bus stimulus.

## Interface
Parameters:
- POLL_GAP, 4: idle cycles (PSEL=0) between consecutive poll reads; 0 allowed.
- MAX_POLLS, 1024: maximum poll reads before timeout; 0 = unlimited; legal range 0..65535.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETB  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle job request; honoured only in IDLE.
- cfg_command  in  3  command value written to 0x00.
- cfg_input_len  in  9  written to 0x04.
- cfg_output_len  in  9  written to 0x08.
- cfg_width  in  9  written to 0x0C.
- cfg_wait_sel  in  2  flag to poll: address 0x10 + 4*cfg_wait_sel (feature, bias, weight, conv done).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end (success or timeout).
- timeout  out  1  one-cycle pulse coincident with done when the poll limit was hit.
- last_status  out  32  PRDATA captured by the most recent poll read.
- PADDR  out  32  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PWDATA  out  32  APB write data; unused upper bits are 0.
- PRDATA  in  32  APB read data; valid only during ACCESS.

## Operation
- States: IDLE, SETUP, ACCESS, GAP, FIN.
- Step index 0..5 selects the transfer:
  - 0: write 0x04 = input_len.
  - 1: write 0x08 = output_len.
  - 2: write 0x0C = width.
  - 3: write 0x00 = command.
  - 4: read poll address.
  - 5: write 0x00 = 0.
- IDLE + start: latch all cfg_* inputs, step=0, poll_cnt=0, go to SETUP. cfg_* changes after the start cycle are ignored.
- SETUP: PSEL=1, PENABLE=0, with PADDR, PWRITE and PWDATA for the current step. Always go to ACCESS next.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA stay identical to SETUP.
- Leaving ACCESS after a write (steps 0..3): step+1, go to SETUP back-to-back with no idle cycle.
- Leaving ACCESS after a poll read (step 4):
  - Capture PRDATA into last_status and increment poll_cnt (16-bit, saturating).
  - If PRDATA[0]=1: step=5, go to SETUP.
  - Else if MAX_POLLS≠0 and poll_cnt (after increment) == MAX_POLLS: set the timeout flag, step=5, go to SETUP.
  - Else: if POLL_GAP>0 go to GAP, otherwise go to SETUP.
- GAP: all APB outputs 0. Count POLL_GAP cycles, then go to SETUP for step 4.
- Leaving ACCESS of step 5: go to FIN.
- FIN: done=1 for one cycle; timeout=1 that same cycle if the flag is set. Then go to IDLE.
- start while busy, or in FIN: ignored, not queued.
- A timeout still performs the step-5 clear write.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - busy, done, timeout = 0; last_status = 0; poll_cnt = 0.
- Reset mid-transfer drops PSEL that same instant. No transfer resumes after reset release.
- All outputs are registered. No combinational path from PRDATA or start to any output.
- Cycle 0 is start sampled high in IDLE. Cycles 1–8 are four writes at 2 cycles each.
- Success on the first poll:
  - Poll read in cycles 9–10.
  - Clear write in cycles 11–12.
  - done=1 in cycle 13.
  - busy=1 in cycles 1–12 and 0 in cycle 13.
- Each additional poll adds 2+POLL_GAP cycles.
- APB outputs in IDLE, GAP and FIN: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- The slave has no PREADY or PSLVERR. Every transfer is exactly 2 cycles.

## Structure
- Shared package conv_apb_pkg contains:
  - Register address constants: ADDR_COMMAND 0x00, ADDR_INPUT_LEN 0x04, ADDR_OUTPUT_LEN 0x08, ADDR_WIDTH 0x0C, ADDR_FEATURE_DONE 0x10, ADDR_BIAS_DONE 0x14, ADDR_WEIGHT_DONE 0x18, ADDR_CONV_DONE 0x1C.
  - The state enum and the step enum.
- The slave and any testbench use the same package.
- One sub-module, apb_master_xfer, is natural:
  - Accepts req, addr, write, wdata.
  - Drives the SETUP→ACCESS phases.
  - Returns xfer_done and rdata.
  - The sequencer FSM sits on top of it.

## Test plan
- Reset then idle: all outputs 0, no PSEL activity for 20 cycles.
- start with input_len=32, output_len=64, width=28, command=3, wait_sel=3, and the conv_done register of the slave model preset to 1:
  - Four writes 0x04=32, 0x08=64, 0x0C=28, 0x00=3.
  - One read of 0x1C.
  - Write 0x00=0.
  - done in cycle 13, last_status=1.
- Slave flag rises after the 3rd poll with POLL_GAP=4: exactly 3 reads of 0x1C, 4 idle cycles between reads, done in cycle 25, timeout=0.
- MAX_POLLS=2 and the flag never set: 2 reads, clear write 0x00=0, then done and timeout pulse together, last_status=0.
- start pulsed again in cycles 3 and 13: ignored, with no extra transfers. Changing cfg_width at cycle 2 still writes the latched value 28.
- PRESETB asserted during the ACCESS of the 2nd write: PSEL and busy fall immediately. After release, a new start runs a full clean sequence.
